// File: rtl/lvds_video_pkg.sv
// Shared constants and helpers for the LVDS video source.
// Pattern generation is built only when LVDS_PATTERN_EN is defined.
package lvds_video_pkg;

    localparam int LANES  = 6;
    localparam int SLOTS  = 7;
    localparam int WORD_W = LANES * SLOTS;
    localparam int CNT_W  = 12;

    localparam logic [1:0] PAT_EXT   = 2'd0;
    localparam logic [1:0] PAT_BARS  = 2'd1;
    localparam logic [1:0] PAT_GRAD  = 2'd2;
    localparam logic [1:0] PAT_SOLID = 2'd3;

    // bit s is slot s; slot 0 leaves the serializer first
    localparam logic [SLOTS-1:0] CLK_PAT = 7'b1100011;

    localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
    localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
    localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] RGB_RED     = 24'hFF0000;
    localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
    localparam logic [23:0] RGB_BLACK   = 24'h000000;

    function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
        logic [23:0] c;
        unique case (idx)
            3'd0: c = RGB_WHITE;
            3'd1: c = RGB_YELLOW;
            3'd2: c = RGB_CYAN;
            3'd3: c = RGB_GREEN;
            3'd4: c = RGB_MAGENTA;
            3'd5: c = RGB_RED;
            3'd6: c = RGB_BLUE;
            3'd7: c = RGB_BLACK;
        endcase
        return c;
    endfunction

    // VESA 4-data-lane layout plus clock lane; word bit = LANES*slot+lane
    function automatic logic [WORD_W-1:0] pack_word(
        input logic [23:0] rgb,
        input logic        hs,
        input logic        vs,
        input logic        de
    );
        logic [LANES-1:0][SLOTS-1:0] ln;
        logic [WORD_W-1:0]           w;
        ln[0] = {rgb[8], rgb[21:16]};
        ln[1] = {rgb[1:0], rgb[13:9]};
        ln[2] = {de, vs, hs, rgb[5:2]};
        ln[3] = {1'b0, rgb[7:6], rgb[15:14], rgb[23:22]};
        ln[4] = CLK_PAT;
        ln[5] = '0;
        w = '0;
        for (int s = 0; s < SLOTS; s++) begin
            for (int l = 0; l < LANES; l++) begin
                w[LANES*s+l] = ln[l][s];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/lvds_video_source_if.sv
// Pixel-side bundle of the LVDS video source.
// master = the source block, slave = whoever drives/consumes it.
interface lvds_video_source_if;
    import lvds_video_pkg::*;

    logic              enable;
    logic [1:0]        pattern_sel;
    logic [23:0]       ext_rgb;
    logic              pix_req;
    logic              frame_start;
    logic [WORD_W-1:0] lvds_word;

    modport master (
        input  enable, pattern_sel, ext_rgb,
        output pix_req, frame_start, lvds_word
    );

    modport slave (
        output enable, pattern_sel, ext_rgb,
        input  pix_req, frame_start, lvds_word
    );

endinterface

// File: rtl/lvds_video_timing.sv
// Raster counters and stage-0 DE/HS/VS/frame_start decode.
// frame_cnt and pattern taps exist only with LVDS_PATTERN_EN.
module lvds_video_timing
    import lvds_video_pkg::*;
#(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       en_i,
`ifdef LVDS_PATTERN_EN
    output logic [7:0] h_lo_o,
    output logic [7:0] v_lo_o,
    output logic [7:0] frame_cnt_o,
    output logic       h_last_o,
`endif
    output logic       active_o,
    output logic       hs_o,
    output logic       vs_o,
    output logic       frame_start_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_ACT = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SS  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SE  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] H_END = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_ACT = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SS  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SE  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_END = CNT_W'(V_TOTAL - 1);

    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    logic             h_last, v_last;
`ifdef LVDS_PATTERN_EN
    logic [7:0]       frame_q, frame_d;
`endif

    assign h_last = (h_q == H_END);
    assign v_last = (v_q == V_END);

    // next raster position; everything holds while disabled
    always_comb begin
        h_d = h_q;
        v_d = v_q;
`ifdef LVDS_PATTERN_EN
        frame_d = frame_q;
`endif
        if (en_i) begin
            if (h_last) begin
                h_d = '0;
                if (v_last) begin
                    v_d = '0;
`ifdef LVDS_PATTERN_EN
                    frame_d = frame_q + 8'd1;
`endif
                end else begin
                    v_d = v_q + CNT_W'(1);
                end
            end else begin
                h_d = h_q + CNT_W'(1);
            end
        end
    end

    // raster position registers
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            h_q <= '0;
            v_q <= '0;
`ifdef LVDS_PATTERN_EN
            frame_q <= '0;
`endif
        end else begin
            h_q <= h_d;
            v_q <= v_d;
`ifdef LVDS_PATTERN_EN
            frame_q <= frame_d;
`endif
        end
    end

    assign active_o = (h_q < H_ACT) && (v_q < V_ACT);
    assign hs_o = (h_q >= H_SS && h_q < H_SE) ? HS_POL : !HS_POL;
    assign vs_o = (v_q >= V_SS && v_q < V_SE) ? VS_POL : !VS_POL;
    assign frame_start_o = en_i && (h_q == '0) && (v_q == '0);

`ifdef LVDS_PATTERN_EN
    assign h_lo_o      = h_q[7:0];
    assign v_lo_o      = v_q[7:0];
    assign frame_cnt_o = frame_q;
    assign h_last_o    = h_last;
`endif

endmodule

// File: rtl/lvds_video_source.sv
// Raster timing, pixel source select and 42-bit LVDS word packing.
// Define LVDS_PATTERN_EN to build the test-pattern generators.
module lvds_video_source
    import lvds_video_pkg::*;
#(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic                pclk,
    input  logic                reset,
    lvds_video_source_if.master vif
);

    localparam logic [WORD_W-1:0] BLANK_WORD =
        pack_word(24'h0, !HS_POL, !VS_POL, 1'b0);

    logic run;
    logic active, hs, vs, fs;
    logic src_ext;

    // reset also silences the combinational request outputs
    assign run = vif.enable && !reset;

`ifdef LVDS_PATTERN_EN
    localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(H_ACTIVE / 8 - 1);

    logic [7:0]       h_lo, v_lo, frame_cnt;
    logic             h_last;
    logic [1:0]       sel_q, sel_d, sel_cur;
    logic [CNT_W-1:0] bar_px_q, bar_px_d;
    logic [2:0]       bar_idx_q, bar_idx_d;
    logic [23:0]      pat_rgb;
`else
    logic [1:0]       unused_sel;
    assign unused_sel = vif.pattern_sel;
`endif

    lvds_video_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(HS_POL), .VS_POL(VS_POL)
    ) u_timing (
        .pclk          (pclk),
        .reset         (reset),
        .en_i          (run),
`ifdef LVDS_PATTERN_EN
        .h_lo_o        (h_lo),
        .v_lo_o        (v_lo),
        .frame_cnt_o   (frame_cnt),
        .h_last_o      (h_last),
`endif
        .active_o      (active),
        .hs_o          (hs),
        .vs_o          (vs),
        .frame_start_o (fs)
    );

`ifdef LVDS_PATTERN_EN
    // the new selection applies from the frame_start cycle itself
    always_comb begin
        sel_cur = fs ? vif.pattern_sel : sel_q;
        sel_d   = sel_cur;
    end

    // bar position tracks h_cnt without a divider
    always_comb begin
        bar_px_d  = bar_px_q;
        bar_idx_d = bar_idx_q;
        if (run) begin
            if (h_last) begin
                bar_px_d  = '0;
                bar_idx_d = '0;
            end else if (bar_px_q == BAR_LAST) begin
                bar_px_d  = '0;
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_px_d  = bar_px_q + CNT_W'(1);
            end
        end
    end

    // selection latch and bar counters
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            sel_q     <= PAT_EXT;
            bar_px_q  <= '0;
            bar_idx_q <= '0;
        end else begin
            sel_q     <= sel_d;
            bar_px_q  <= bar_px_d;
            bar_idx_q <= bar_idx_d;
        end
    end

    // stage-0 pattern colour for the current position
    always_comb begin
        pat_rgb = '0;
        unique case (sel_cur)
            PAT_EXT:   pat_rgb = '0;
            PAT_BARS:  pat_rgb = bar_rgb(bar_idx_q);
            PAT_GRAD:  pat_rgb = {h_lo, v_lo, frame_cnt};
            PAT_SOLID: pat_rgb = RGB_WHITE;
        endcase
    end

    assign src_ext = (sel_cur == PAT_EXT);
`else
    assign src_ext = 1'b1;
`endif

    logic        de_q, de_d, hs_q, hs_d, vs_q, vs_d;
`ifdef LVDS_PATTERN_EN
    logic        ext_q, ext_d;
    logic [23:0] pat_q, pat_d;
`endif
    logic [23:0]       rgb_s1;
    logic [WORD_W-1:0] word_q, word_d;

    // stage-1 inputs; disabled cycles load blanking
    always_comb begin
        de_d = active && run;
        hs_d = run ? hs : !HS_POL;
        vs_d = run ? vs : !VS_POL;
`ifdef LVDS_PATTERN_EN
        ext_d = src_ext;
        pat_d = pat_rgb;
`endif
    end

    // stage-1 registers
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            de_q <= 1'b0;
            hs_q <= !HS_POL;
            vs_q <= !VS_POL;
`ifdef LVDS_PATTERN_EN
            ext_q <= 1'b0;
            pat_q <= '0;
`endif
        end else begin
            de_q <= de_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
`ifdef LVDS_PATTERN_EN
            ext_q <= ext_d;
            pat_q <= pat_d;
`endif
        end
    end

    // stage-1 pixel: ext_rgb arrives this cycle, blanked outside DE
    always_comb begin
        rgb_s1 = '0;
        if (de_q) begin
`ifdef LVDS_PATTERN_EN
            rgb_s1 = ext_q ? vif.ext_rgb : pat_q;
`else
            rgb_s1 = vif.ext_rgb;
`endif
        end
        word_d = pack_word(rgb_s1, hs_q, vs_q, de_q);
    end

    // stage-2 serializer word
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            word_q <= BLANK_WORD;
        end else begin
            word_q <= word_d;
        end
    end

    assign vif.lvds_word   = word_q;
    assign vif.pix_req     = active && run && src_ext;
    assign vif.frame_start = fs;

endmodule

// File: tb/tb_lvds_video_source.sv
// Scoreboard bench for lvds_video_source on a 24x8 raster.
// Pattern expectations follow LVDS_PATTERN_EN when it is defined.
module tb_lvds_video_source;

    localparam int HA = 16, HF = 2, HSW = 2, HB = 4;
    localparam int VA = 4, VF = 1, VSW = 1, VB = 2;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;

    localparam bit [6:0] CLK_LANE = 7'b1100011;
    localparam int MAP [0:3][0:6] = '{
        '{16, 17, 18, 19, 20, 21, 8},
        '{9, 10, 11, 12, 13, 0, 1},
        '{2, 3, 4, 5, 24, 25, 26},
        '{22, 23, 14, 15, 6, 7, 27}
    };
    localparam logic [23:0] BARS [0:7] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    logic pclk = 1'b0;
    logic reset;

    lvds_video_source_if vif();

    lvds_video_source #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .pclk  (pclk),
        .reset (reset),
        .vif   (vif)
    );

    always #5 pclk = ~pclk;

    int          ncmp = 0;
    int          nerr = 0;
    logic [41:0] exp_q [$];
    int          mh, mv;
    logic [7:0]  mframe;
    logic [1:0]  msel;
    logic        have_pend, want_a5;
    logic [23:0] pend_rgb;

    function automatic logic [41:0] mk_word(
        input logic [23:0] rgb, input logic hs, input logic vs, input logic de
    );
        logic [27:0] src;
        logic [41:0] w;
        src = {1'b0, de, vs, hs, rgb};
        w = '0;
        for (int s = 0; s < 7; s++) begin
            for (int l = 0; l < 4; l++) w[6*s+l] = src[MAP[l][s]];
            w[6*s+4] = CLK_LANE[s];
        end
        return w;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (h=%0d v=%0d t=%0t)",
                     tag, got, exp, mh, mv, $time);
        end
    endtask

    task automatic do_reset(input int n);
        logic [41:0] blank;
        blank = mk_word(24'h0, 1'b1, 1'b1, 1'b0);
        @(negedge pclk);
        reset = 1'b1;
        mh = 0; mv = 0; mframe = '0; msel = 2'd0; have_pend = 1'b0;
        exp_q.delete();
        exp_q.push_back(blank);
        exp_q.push_back(blank);
        repeat (n) begin
            #1;
            check("rst_word", vif.lvds_word, blank);
            check("rst_pix_req", vif.pix_req, 1'b0);
            check("rst_frame_start", vif.frame_start, 1'b0);
            @(negedge pclk);
        end
    endtask

    task automatic cycle(input logic en, input logic [1:0] sel);
        logic        act, de, fs, pr, hsb, vsb, l5;
        logic [1:0]  cur;
        logic [23:0] rgb;
        logic [41:0] got_w;
        logic [6:0]  clk_l;
        @(negedge pclk);
        reset = 1'b0;
        vif.ext_rgb = have_pend ? pend_rgb : 24'($urandom);
        vif.enable = en;
        vif.pattern_sel = sel;
        #1;
        act = (mh < HA) && (mv < VA);
        de  = act && en;
        fs  = en && (mh == 0) && (mv == 0);
`ifdef LVDS_PATTERN_EN
        cur = fs ? sel : msel;
        if (fs) msel = sel;
`else
        cur = 2'd0;
`endif
        pr = de && (cur == 2'd0);
        check("pix_req", vif.pix_req, pr);
        check("frame_start", vif.frame_start, fs);
        have_pend = pr;
        rgb = '0;
        if (de) begin
            case (cur)
                2'd0: begin
                    pend_rgb = want_a5 ? 24'hA55A3C : 24'($urandom);
                    want_a5 = 1'b0;
                    rgb = pend_rgb;
                end
                2'd1: rgb = BARS[mh / (HA / 8)];
                2'd2: rgb = {8'(mh), 8'(mv), mframe};
                default: rgb = 24'hFFFFFF;
            endcase
        end
        hsb = !(en && mh >= HA + HF && mh < HA + HF + HSW);
        vsb = !(en && mv >= VA + VF && mv < VA + VF + VSW);
        exp_q.push_back(mk_word(rgb, hsb, vsb, de));
        got_w = vif.lvds_word;
        check("lvds_word", got_w, exp_q.pop_front());
        l5 = 1'b0;
        for (int s = 0; s < 7; s++) begin
            clk_l[s] = got_w[6*s+4];
            l5 = l5 | got_w[6*s+5];
        end
        check("clk_lane", clk_l, CLK_LANE);
        check("lane5", l5, 1'b0);
        if (en) begin
            if (mh == HT - 1) begin
                mh = 0;
                if (mv == VT - 1) begin
                    mv = 0;
                    mframe = mframe + 8'd1;
                end else begin
                    mv = mv + 1;
                end
            end else begin
                mh = mh + 1;
            end
        end
    endtask

    task automatic run(input int n, input logic en, input logic [1:0] sel);
        for (int i = 0; i < n; i++) cycle(en, sel);
    endtask

    initial begin
        reset = 1'b1;
        vif.enable = 1'b1;
        vif.pattern_sel = 2'd3;
        vif.ext_rgb = '0;
        have_pend = 1'b0;
        want_a5 = 1'b0;
        pend_rgb = '0;
        mh = 0; mv = 0; mframe = '0; msel = 2'd0;

        do_reset(3);
        run(192, 1'b1, 2'd3);
        want_a5 = 1'b1;
        run(192, 1'b1, 2'd0);
        run(100, 1'b1, 2'd1);
        run(284, 1'b1, 2'd2);
        run(10, 1'b1, 2'd2);
        run(5, 1'b0, 2'd2);
        run(40, 1'b1, 2'd2);
        do_reset(2);
        run(200, 1'b1, 2'd0);
        run(3, 1'b0, 2'd0);
        run(30, 1'b1, 2'd0);
        run(5, 1'b0, 2'd3);
        run(20, 1'b1, 2'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
